// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR level generator (0..63) stepped on a prescaled tick; define ADSR_EXP_RELEASE_EN for a pseudo-exponential release tail
module adsr_envelope #(
  parameter int TICK_DIV = 1024,
  parameter int RATE_W   = 16
) (
  input  logic       clk,
  input  logic       rst_active_high,
  input  logic       gate,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [5:0] sustain_level,
  input  logic [3:0] release_rate,
  output logic [5:0] vol,
  output logic       active,
  output logic [2:0] env_state
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  state_t state_q, state_d;
  logic gate_q, active_q, active_d, rise, fall, tick, step;
  logic [PW-1:0] presc_q, presc_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d, period;
  logic [5:0] level_q, level_d, rel_dec;
  logic [3:0] rate;
  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign tick = presc_q == PW'(TICK_DIV - 1);
  assign rate = state_q == ATTACK ? attack_rate : state_q == DECAY ? decay_rate :
                state_q == RELEASE ? release_rate : 4'd0;
  assign period = (RATE_W'(1) << rate) - RATE_W'(1);
  assign step = tick && rate_cnt_q >= period;
  assign vol = level_q;
  assign active = active_q;
  assign env_state = state_q;
  // release decrement: linear, or level/8 with a floor of 1 for the exponential tail
  always_comb begin
`ifdef ADSR_EXP_RELEASE_EN
    rel_dec = level_q[5:3] == 3'd0 ? 6'd1 : {3'b000, level_q[5:3]};
`else
    rel_dec = 6'd1;
`endif
  end
  // phase transitions and level stepping; a gate edge always wins over a step
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      IDLE: if (rise) state_d = ATTACK;
      ATTACK:
        if (fall) state_d = RELEASE;
        else if (level_q == 6'd63) state_d = sustain_level == 6'd63 ? SUSTAIN : DECAY;
        else if (step) level_d = level_q + 6'd1;
      DECAY:
        if (fall) state_d = RELEASE;
        else if (level_q <= sustain_level) state_d = SUSTAIN;
        else if (step) level_d = level_q - 6'd1;
      SUSTAIN: if (fall) state_d = RELEASE;
      RELEASE:
        if (rise) state_d = ATTACK;
        else if (level_q == 6'd0) state_d = IDLE;
        else if (step) level_d = level_q > rel_dec ? level_q - rel_dec : 6'd0;
      default: state_d = IDLE;
    endcase
    presc_d = tick ? '0 : presc_q + PW'(1);
    rate_cnt_d = (state_d != state_q || step) ? '0 : tick ? rate_cnt_q + RATE_W'(1) : rate_cnt_q;
    active_d = state_d != IDLE;
  end
  // state, level, prescaler and rate counter registers
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state_q    <= IDLE;
      level_q    <= '0;
      active_q   <= 1'b0;
      gate_q     <= 1'b0;
      presc_q    <= '0;
      rate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      active_q   <= active_d;
      gate_q     <= gate;
      presc_q    <= presc_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: scoreboard bench comparing adsr_envelope against a behavioural envelope model
module tb_adsr_envelope;
  localparam int TD = 4;
  logic clk = 1'b0, rst, gate;
  logic [3:0] a_r, d_r, r_r;
  logic [5:0] s_l, vol;
  logic active;
  logic [2:0] env_state;
  int q[$];
  int n_chk = 0, n_pass = 0;
  int m_lvl, m_st, m_presc, m_ticks;
  bit m_gq;

  adsr_envelope #(.TICK_DIV(TD), .RATE_W(16)) dut (
    .clk(clk), .rst_active_high(rst), .gate(gate), .attack_rate(a_r), .decay_rate(d_r),
    .sustain_level(s_l), .release_rate(r_r), .vol(vol), .active(active), .env_state(env_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic model_reset();
    m_lvl = 0; m_st = 0; m_presc = 0; m_ticks = 0; m_gq = 0;
  endtask

  // states: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  task automatic model_clk(input bit g);
    bit tick, rise, fall, stp;
    int rate, nt, nst, nl, sub;
    tick = m_presc == TD - 1;
    m_presc = (m_presc + 1) % TD;
    rise = g && !m_gq;
    fall = !g && m_gq;
    m_gq = g;
    rate = m_st == 1 ? int'(a_r) : m_st == 2 ? int'(d_r) : m_st == 4 ? int'(r_r) : 0;
    nt = m_ticks + (tick ? 1 : 0);
    stp = tick && nt >= (1 << rate);
`ifdef ADSR_EXP_RELEASE_EN
    sub = (m_lvl / 8 > 1) ? m_lvl / 8 : 1;
`else
    sub = 1;
`endif
    nst = m_st;
    nl = m_lvl;
    if (m_st == 0) begin
      if (rise) nst = 1;
    end else if (m_st != 4 && fall) nst = 4;
    else if (m_st == 1) begin
      if (m_lvl == 63) nst = (s_l == 63) ? 3 : 2;
      else if (stp) nl = m_lvl + 1;
    end else if (m_st == 2) begin
      if (m_lvl <= int'(s_l)) nst = 3;
      else if (stp) nl = m_lvl - 1;
    end else if (m_st == 4) begin
      if (rise) nst = 1;
      else if (m_lvl == 0) nst = 0;
      else if (stp) nl = (m_lvl - sub < 0) ? 0 : m_lvl - sub;
    end
    m_ticks = (nst != m_st || stp) ? 0 : nt;
    m_st = nst;
    m_lvl = nl;
  endtask

  // called at a negedge: drive, predict the next posedge, then wait one cycle
  task automatic cyc(input bit g);
    gate = g;
    if (rst) model_reset();
    else model_clk(g);
    q.push_back((m_lvl << 4) | ((m_st != 0 ? 1 : 0) << 3) | m_st);
    @(negedge clk);
  endtask

  initial begin
    int exp, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp = q.pop_front();
        got = (int'(vol) << 4) | (int'(active) << 3) | int'(env_state);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL sb @%0t: got vol=%0d act=%0d st=%0d expected vol=%0d act=%0d st=%0d",
                      $time, got >> 4, (got >> 3) & 1, got & 7, exp >> 4, (exp >> 3) & 1, exp & 7);
      end
    end
  end

  initial begin
    int hi, lo;
    rst = 1'b1; gate = 1'b0; a_r = 0; d_r = 0; r_r = 0; s_l = 6'd63;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_vol", vol, 0);
    chk("rst_state", env_state, 0);
    chk("rst_active", active, 0);
    rst = 1'b0;
    repeat (260) cyc(1);
    chk("atk_peak_vol", vol, 63);
    chk("atk_peak_state", env_state, 3);
    repeat (20) cyc(1);
    chk("sus63_hold", vol, 63);
    repeat (300) cyc(0);
    chk("rel_idle_state", env_state, 0);
    chk("rel_idle_active", active, 0);
    d_r = 1; s_l = 6'd32;
    repeat (600) cyc(1);
    chk("decay_vol", vol, 32);
    chk("decay_state", env_state, 3);
    repeat (1000) cyc(1);
    chk("sus32_hold", vol, 32);
    cyc(0);
    chk("fall_state", env_state, 4);
    chk("fall_vol", vol, 32);
    repeat (140) cyc(0);
    chk("rel_end_vol", vol, 0);
    chk("rel_end_state", env_state, 0);
    chk("rel_end_active", active, 0);
    s_l = 6'd63;
    repeat (270) cyc(1);
    for (int i = 0; i < 400 && m_lvl != 10; i++) cyc(0);
    chk("rel10_vol", vol, 10);
    cyc(1);
    chk("reatk_state", env_state, 1);
    chk("reatk_vol", vol, 10);
    repeat (8) cyc(1);
    chk("reatk_up", int'(vol > 6'd10), 1);
    for (int i = 0; i < 300 && !(m_lvl == 40 && m_presc == TD - 1); i++) cyc(1);
    chk("coin_pre_vol", vol, 40);
    cyc(0);
    chk("coin_state", env_state, 4);
    chk("coin_vol", vol, 40);
    repeat (400) cyc(0);
    for (int i = 0; i < 200 && m_lvl != 20; i++) cyc(1);
    chk("arst_pre_vol", vol, 20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_vol", vol, 0);
    chk("arst_state", env_state, 0);
    chk("arst_active", active, 0);
    model_reset();
    @(negedge clk);
    repeat (2) cyc(0);
    rst = 1'b0;
    cyc(0);
    cyc(1);
    chk("post_rst_state", env_state, 1);
    chk("post_rst_vol", vol, 0);
    for (int n = 0; n < 30; n++) begin
      a_r = 4'($urandom_range(0, 2));
      d_r = 4'($urandom_range(0, 2));
      r_r = 4'($urandom_range(0, 2));
      s_l = 6'($urandom_range(0, 63));
      hi = $urandom_range(0, 700);
      lo = $urandom_range(0, 500);
      for (int i = 0; i < hi; i++) begin
        if ($urandom_range(0, 63) == 0) s_l = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 63) == 0) a_r = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 63) == 0) d_r = 4'($urandom_range(0, 3));
        cyc(1);
      end
      for (int i = 0; i < lo; i++) begin
        if ($urandom_range(0, 63) == 0) r_r = 4'($urandom_range(0, 3));
        cyc(0);
      end
    end
    @(posedge clk);
    #2;
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
